vec_mem_sequencer: RTL
======================

Name: vec_mem_sequencer

Overview:
- Memory-stage controller between the Execute/Memory pipeline register outputs and a single N-bit data-memory port.
- Passes scalar loads/stores through in one cycle.
- Serialises each V-bit vector load/store into V/N consecutive N-bit beats.
- Holds the Execute/Memory and Memory/Writeback registers with a stall (register enable = ~stall_o) until the access completes.

Parameters:
- N, 32, scalar word width and memory port width.
- V, 256, vector width; must be an integer multiple of N.
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- vec_req_i  in  1  vector memory access present in Memory stage
- vec_we_i  in  1  1 = vector store, 0 = vector load
- scl_req_i  in  1  scalar memory access present in Memory stage
- scl_we_i  in  1  1 = scalar store
- addr_i  in  N  byte address (ALU result from the Memory stage)
- wdata_s_i  in  N  scalar store data
- wdata_v_i  in  V  vector store data
- mem_req_o  out  1  memory port request
- mem_we_o  out  1  memory port write enable
- mem_addr_o  out  N  memory port byte address
- mem_wdata_o  out  N  memory port write data
- mem_ready_i  in  1  memory accepts the beat this cycle; read data valid in the same cycle
- mem_rdata_i  in  N  memory read data
- rdata_s_o  out  N  scalar load result (combinational pass of mem_rdata_i)
- rdata_v_o  out  V  assembled vector load result
- stall_o  out  1  pipeline stall, active-high
- done_o  out  1  one-cycle pulse when a vector access completes
- err_o  out  1  sticky timeout error

Behaviour:
- States: IDLE, BURST, DONE. Reset: IDLE, beat counter 0, shadow registers 0.
- Reset output values: rdata_v_o=0, stall_o=0, done_o=0, err_o=0, mem_req_o=0.
- Reset mid-burst aborts the burst. No further beats are issued.
- IDLE, scalar access (scl_req_i=1, vec_req_i=0):
  - mem_req_o=1, mem_we_o=scl_we_i, mem_addr_o=addr_i, mem_wdata_o=wdata_s_i.
  - stall_o = ~mem_ready_i.
  - No state change.
- IDLE, vector access (vec_req_i=1):
  - Vector has priority; any scalar request is ignored.
  - Latch addr_i, vec_we_i and wdata_v_i into shadow registers. Beat counter = 0.
  - stall_o=1 in this cycle. mem_req_o=0. Go to BURST next cycle.
- BURST:
  - mem_req_o=1, mem_we_o=shadow we.
  - mem_addr_o = shadow addr + beat*(N/8), modulo 2^N (address wraps silently).
  - mem_wdata_o = shadow wdata[beat*N +: N].
  - On mem_ready_i: for a load, capture mem_rdata_i into rdata_v_o[beat*N +: N]; then increment beat.
  - When the last beat (V/N-1) is accepted, go to DONE. Otherwise stay in BURST.
  - mem_ready_i low holds the beat, address and data unchanged.
  - stall_o=1 throughout BURST.
- DONE:
  - stall_o=0 and done_o=1 for exactly one cycle. rdata_v_o valid. mem_req_o=0.
  - The pipeline advances on this edge. Next state is IDLE.
  - The old vec_req_i is therefore never re-sampled.
- rdata_v_o holds its value until the next vector load starts capturing.
- Vector stores leave rdata_v_o unchanged.
- Burst latency, zero-wait memory: V/N + 2 cycles from vec_req_i to done_o, i.e. 10 cycles at the defaults.
- vec_req_i=0 and scl_req_i=0 in IDLE: all outputs idle, stall_o=0.

Optional Feature:
- Macro: VEC_MEM_SEQ_TIMEOUT_EN.
- Enabled:
  - A counter counts consecutive BURST cycles with mem_ready_i=0.
  - When it reaches TIMEOUT, abort to IDLE, set err_o (sticky until rst) and pulse done_o. rdata_v_o is not updated further.
  - The counter clears on any accepted beat.
- Disabled: no counter. err_o tied 0. BURST waits indefinitely.

Decomposition:
- Package vec_mem_pkg:
  - State enum (IDLE, BURST, DONE).
  - BEATS = V/N; BEAT_W = $clog2(BEATS); BYTE_STRIDE = N/8.
- Sub-module vec_lane_buffer:
  - V-bit register with lane-indexed N-bit write and clear.
  - Instantiated twice: write shadow and read assembly.

Test Plan:
- Scalar load, addr_i=0x100, mem_ready_i=1, mem_rdata_i=0xDEADBEEF -> mem_addr_o=0x100, rdata_s_o=0xDEADBEEF, stall_o=0, same cycle.
- Vector load at 0x200, zero-wait, memory returns word k = k+1 -> addresses 0x200..0x21C step 4, stall_o high for 9 cycles, done_o pulse, rdata_v_o lane k = k+1.
- Vector store at 0x300, wdata lane k = 0xA0+k, mem_ready_i low on beat 3 for 2 cycles -> beat 3 address/data held, 8 writes total, done_o at cycle 12.
- Vector store at base 0xFFFFFFF0 -> beats 4..7 wrap to 0x00000000..0x0000000C.
- rst asserted during beat 5 of a load -> next cycle IDLE, stall_o=0, rdata_v_o=0, mem_req_o=0.
- TIMEOUT_EN, TIMEOUT=64, mem_ready_i stuck low -> abort after 64 cycles, err_o=1 and stays 1, done_o pulse, stall_o drops.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared types and sizing helpers for the vector memory-stage sequencer.
package vec_mem_pkg;

  localparam int unsigned DEF_N = 32;
  localparam int unsigned DEF_V = 256;

  // Sizing at the default configuration
  localparam int unsigned BEATS       = DEF_V / DEF_N;
  localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BYTE_STRIDE = DEF_N / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Beat-index width for an arbitrary beat count (never zero bits wide)
  function automatic int unsigned beat_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vec_lane_buffer.sv
// V-bit register split into N-bit lanes: full parallel load, single-lane
// write, and clear. Used both as the store-data shadow and the load assembly
// buffer of vec_mem_sequencer.
module vec_lane_buffer
  import vec_mem_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned V      = DEF_V,
  parameter int unsigned LANE_W = beat_width(DEF_V / DEF_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [V-1:0]      load_data,
  input  logic              wr,
  input  logic [LANE_W-1:0] lane,
  input  logic [N-1:0]      wdata,
  output logic [V-1:0]      q
);

  // Clear has priority over a full load, which has priority over a lane write
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (wr) begin
      q[lane*N +: N] <= wdata;
    end
  end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Memory-stage controller: scalar accesses pass straight to the N-bit memory
// port; vector accesses are serialised into V/N beats while the pipeline is
// stalled.
// Optional build macro: VEC_MEM_SEQ_TIMEOUT_EN adds a burst watchdog that
// aborts after TIMEOUT consecutive not-ready cycles and raises sticky err_o.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned V       = DEF_V,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vec_req_i,
  input  logic         vec_we_i,
  input  logic         scl_req_i,
  input  logic         scl_we_i,
  input  logic [N-1:0] addr_i,
  input  logic [N-1:0] wdata_s_i,
  input  logic [V-1:0] wdata_v_i,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [N-1:0] mem_rdata_i,
  output logic [N-1:0] rdata_s_o,
  output logic [V-1:0] rdata_v_o,
  output logic         stall_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int unsigned NBEATS = V / N;
  localparam int unsigned CNT_W  = beat_width(NBEATS);
  localparam int unsigned STRIDE = N / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if ((V < N) || ((V % N) != 0) || ((N % 8) != 0) || (TIMEOUT == 0)) begin : g_bad_cfg
    $error("vec_mem_sequencer: V must be a non-zero multiple of N, N a multiple of 8, TIMEOUT > 0");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] beat;
  logic [N-1:0]     sh_addr;
  logic             sh_we;
  logic [V-1:0]     sh_wdata;
  logic             sh_load;
  logic             rd_wr;
  logic             beat_acc;
  logic             abort;

  assign rdata_s_o = mem_rdata_i;

  // Store-data shadow: captured once when a vector access enters, read lane by lane
  vec_lane_buffer #(
    .N      (N),
    .V      (V),
    .LANE_W (CNT_W)
  ) u_wr_shadow (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load      (sh_load),
    .load_data (wdata_v_i),
    .wr        (1'b0),
    .lane      (beat),
    .wdata     ('0),
    .q         (sh_wdata)
  );

  // Load assembly: each accepted load beat fills its lane; stores leave it untouched
  vec_lane_buffer #(
    .N      (N),
    .V      (V),
    .LANE_W (CNT_W)
  ) u_rd_assembly (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load      (1'b0),
    .load_data ('0),
    .wr        (rd_wr),
    .lane      (beat),
    .wdata     (mem_rdata_i),
    .q         (rdata_v_o)
  );

`ifdef VEC_MEM_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err;

  // Abort on the TIMEOUT-th consecutive stalled burst cycle
  assign abort = (state == BURST) && !mem_ready_i && (to_cnt == TO_W'(TIMEOUT - 1));
  assign err_o = err;

  // Watchdog: count consecutive not-ready burst cycles; error is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state != BURST) || mem_ready_i) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (abort) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  // State, beat counter and address/direction shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      sh_addr <= '0;
      sh_we   <= 1'b0;
    end else begin
      state <= state_next;
      if (sh_load) begin
        sh_addr <= addr_i;
        sh_we   <= vec_we_i;
        beat    <= '0;
      end else if (beat_acc) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
    end
  end

  // Next state and memory-port / pipeline outputs; everything idles while rst is high
  always_comb begin
    state_next  = state;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    sh_load     = 1'b0;
    rd_wr       = 1'b0;
    beat_acc    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (vec_req_i) begin
            sh_load    = 1'b1;
            stall_o    = 1'b1;
            state_next = BURST;
          end else if (scl_req_i) begin
            mem_req_o   = 1'b1;
            mem_we_o    = scl_we_i;
            mem_addr_o  = addr_i;
            mem_wdata_o = wdata_s_i;
            stall_o     = ~mem_ready_i;
          end
        end
        BURST: begin
          mem_req_o   = 1'b1;
          mem_we_o    = sh_we;
          mem_addr_o  = sh_addr + N'(beat) * N'(STRIDE);
          mem_wdata_o = sh_wdata[beat*N +: N];
          stall_o     = 1'b1;
          if (mem_ready_i) begin
            beat_acc = 1'b1;
            rd_wr    = ~sh_we;
            if (beat == LAST_BEAT) begin
              state_next = DONE;
            end
          end else if (abort) begin
            state_next = DONE;
          end
        end
        DONE: begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
